multiplicador_secuencial: RTL

MULTIPLICADOR_SECUENCIAL -- requirements
Module: multiplicador_secuencial

---
 rtl/multiplicador_secuencial.sv | 88 ++++++++
 1 files changed

// File: rtl/multiplicador_secuencial.sv
// Sequential unsigned shift-add multiplier: N iterations per product, result
// registered on entry to DONE, back-to-back operation accepted from DONE.
module multiplicador_secuencial #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] prod,
    output logic           busy,
    output logic           done
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t         state_reg, state_next;
    logic [N-1:0]   a_reg, a_next;
    logic [N-1:0]   hi_reg, hi_next;
    logic [N-1:0]   lo_reg, lo_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [2*N-1:0] prod_reg, prod_next;
    logic [N:0]     sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            cnt_reg   <= '0;
            prod_reg  <= '0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            cnt_reg   <= cnt_next;
            prod_reg  <= prod_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        cnt_next   = cnt_reg;
        prod_next  = prod_reg;
        // The carry bit of this sum is the c of {c,hi,lo}; it is always 0 after the shift.
        sum        = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : {(N+1){1'b0}});

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    a_next     = a;
                    hi_next    = '0;
                    lo_next    = b;
                    cnt_next   = '0;
                    state_next = CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                hi_next = sum[N:1];
                lo_next = {sum[0], lo_reg[N-1:1]};
                if (cnt_reg != CW'(N))
                    cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CW'(N - 1)) begin
                    prod_next  = {sum[N:1], sum[0], lo_reg[N-1:1]};
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign prod = prod_reg;
    assign busy = (state_reg == CALC);
    assign done = (state_reg == DONE);
endmodule
